// File: rtl/sdb_pkg.sv
// Shared types and constants for the signed-digit to two's complement decoder.
package sdb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sdb_dec_state_t;

  // Number of signed digits resolved per clock cycle.
  localparam int DIGITS_PER_STEP = 2;

  // Width of the step counter for a given digit count; never below one bit.
  function automatic int cnt_width(input int width);
    int steps;
    steps = width / DIGITS_PER_STEP;
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/sdb_sub_slice.sv
// Two-digit subtract-with-borrow: {b_out, d} = p - n - b_in.
module sdb_sub_slice (
  input  logic [1:0] p,
  input  logic [1:0] n,
  input  logic       b_in,
  output logic [1:0] d,
  output logic       b_out
);

  logic [2:0] diff;

  // Three-bit difference; its top bit is the borrow into the next pair.
  always_comb begin
    diff  = {1'b0, p} - {1'b0, n} - {2'b00, b_in};
    d     = diff[1:0];
    b_out = diff[2];
  end

endmodule

// File: rtl/sdb_decoder.sv
// Sequential signed-digit to two's complement converter, two digits per cycle,
// least significant pair first, with a borrow chained across cycles.
module sdb_decoder
  import sdb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] pos_i,
  input  logic [WIDTH-1:0] neg_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH:0]   result_o
);

  localparam int STEPS = WIDTH / DIGITS_PER_STEP;
  localparam int CW    = cnt_width(WIDTH);

  sdb_dec_state_t state_q, state_d;

  logic [WIDTH-1:0] pos_q, pos_d;
  logic [WIDTH-1:0] neg_q, neg_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   result_q, result_d;

  logic [1:0] sel_p;
  logic [1:0] sel_n;
  logic [1:0] slice_d;
  logic       slice_borrow;
  logic       last_step;

  assign last_step = (cnt_q == CW'(STEPS - 1));

  // Pick the digit pair addressed by the step counter from the latched operands.
  always_comb begin
    sel_p = 2'b00;
    sel_n = 2'b00;
    for (int k = 0; k < STEPS; k++) begin
      if (cnt_q == CW'(k)) begin
        sel_p = pos_q[2*k +: 2];
        sel_n = neg_q[2*k +: 2];
      end
    end
  end

  sdb_sub_slice u_slice (
    .p     (sel_p),
    .n     (sel_n),
    .b_in  (borrow_q),
    .d     (slice_d),
    .b_out (slice_borrow)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode: accept in IDLE, step through pairs in BUSY, hold in DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid_i) state_d = BUSY;
      BUSY: if (last_step) state_d = DONE;
      DONE: if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs depend on the state register only.
  always_comb begin
    in_ready_o  = (state_q == IDLE);
    out_valid_o = (state_q == DONE);
  end

  // Datapath next values: latch operands on accept, resolve one pair per BUSY cycle.
  always_comb begin
    pos_d    = pos_q;
    neg_d    = neg_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          pos_d    = pos_i;
          neg_d    = neg_i;
          borrow_d = 1'b0;
          cnt_d    = '0;
        end
      end
      BUSY: begin
        borrow_d = slice_borrow;
        cnt_d    = cnt_q + CW'(1);
        for (int k = 0; k < STEPS; k++) begin
          if (cnt_q == CW'(k)) begin
            result_d[2*k +: 2] = slice_d;
          end
        end
        if (last_step) begin
          result_d[WIDTH] = slice_borrow;
          cnt_d           = '0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; the result is only rewritten while BUSY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q    <= '0;
      neg_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      pos_q    <= pos_d;
      neg_q    <= neg_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign result_o = result_q;

endmodule

// File: tb/tb_sdb_decoder.sv
// Self-checking bench for sdb_decoder at WIDTH 4, 8 and 16 against a plain
// integer subtraction model.
module tb_sdb_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  inValid;
  logic [2:0]  inReady;
  logic [2:0]  outValid;
  logic [2:0]  outReady;
  logic [15:0] posB;
  logic [15:0] negB;
  logic [4:0]  res4;
  logic [8:0]  res8;
  logic [16:0] res16;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sdb_decoder #(.WIDTH(4)) dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (inValid[0]),
    .in_ready_o  (inReady[0]),
    .pos_i       (posB[3:0]),
    .neg_i       (negB[3:0]),
    .out_valid_o (outValid[0]),
    .out_ready_i (outReady[0]),
    .result_o    (res4)
  );

  sdb_decoder #(.WIDTH(8)) dut8 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (inValid[1]),
    .in_ready_o  (inReady[1]),
    .pos_i       (posB[7:0]),
    .neg_i       (negB[7:0]),
    .out_valid_o (outValid[1]),
    .out_ready_i (outReady[1]),
    .result_o    (res8)
  );

  sdb_decoder #(.WIDTH(16)) dut16 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (inValid[2]),
    .in_ready_o  (inReady[2]),
    .pos_i       (posB),
    .neg_i       (negB),
    .out_valid_o (outValid[2]),
    .out_ready_i (outReady[2]),
    .result_o    (res16)
  );

  // Hard time limit in case a handshake never completes.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int widthOf(input int idx);
    return 4 << idx;
  endfunction

  function automatic logic [16:0] resOf(input int idx);
    case (idx)
      0:       return {12'd0, res4};
      1:       return {8'd0, res8};
      default: return res16;
    endcase
  endfunction

  // Reference: unsigned pos minus unsigned neg, kept to WIDTH+1 bits.
  function automatic logic [16:0] model(input int w, input logic [15:0] p, input logic [15:0] n);
    longint pv;
    longint nv;
    longint diff;
    longint mask;
    mask = (64'sd1 <<< w) - 1;
    pv   = longint'(p) & mask;
    nv   = longint'(n) & mask;
    diff = pv - nv;
    diff = diff & ((64'sd1 <<< (w + 1)) - 1);
    return diff[16:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full operand: accept, count latency, stall in DONE, release.
  task automatic applyStimulus(input int idx, input logic [15:0] p, input logic [15:0] n,
                               input int stalls);
    logic [16:0] exp;
    int cyc;
    int lat;
    exp = model(widthOf(idx), p, n);
    lat = widthOf(idx) / 2;
    checkOutput("idleReady", 17'(inReady[idx]), 17'd1);
    posB         = p;
    negB         = n;
    inValid[idx] = 1'b1;
    outReady[idx] = 1'($urandom_range(0, 1));
    step();
    inValid[idx] = 1'($urandom_range(0, 1));
    posB         = 16'($urandom);
    negB         = 16'($urandom);
    checkOutput("readyLowAfterAccept", 17'(inReady[idx]), 17'd0);
    cyc = 0;
    while (!outValid[idx] && cyc < 40) begin
      step();
      cyc++;
      if (!outValid[idx]) begin
        inValid[idx]  = 1'($urandom_range(0, 1));
        outReady[idx] = 1'($urandom_range(0, 1));
        posB          = 16'($urandom);
        negB          = 16'($urandom);
      end
    end
    checkOutput("latency", 17'(cyc), 17'(lat));
    checkOutput("resultDone", resOf(idx), exp);
    outReady[idx] = 1'b0;
    for (int s = 0; s < stalls; s++) begin
      inValid[idx] = 1'($urandom_range(0, 1));
      posB         = 16'($urandom);
      negB         = 16'($urandom);
      step();
      checkOutput("stallValid", 17'(outValid[idx]), 17'd1);
      checkOutput("stallReady", 17'(inReady[idx]), 17'd0);
      checkOutput("stallResult", resOf(idx), exp);
    end
    inValid[idx]  = 1'b1;
    outReady[idx] = 1'b1;
    step();
    inValid[idx]  = 1'b0;
    outReady[idx] = 1'b0;
    checkOutput("postValid", 17'(outValid[idx]), 17'd0);
    checkOutput("postReady", 17'(inReady[idx]), 17'd1);
    checkOutput("postResult", resOf(idx), exp);
  endtask

  initial begin
    rst_n    = 1'b0;
    inValid  = '0;
    outReady = '0;
    posB     = '0;
    negB     = '0;
    #12;
    checkOutput("resetReady", 17'(inReady), 17'b111);
    checkOutput("resetValid", 17'(outValid), 17'd0);
    checkOutput("resetRes8", resOf(1), 17'd0);
    checkOutput("resetRes16", resOf(2), 17'd0);
    #5;
    rst_n = 1'b1;
    step();

    $display("[TB] directed WIDTH=8");
    applyStimulus(1, 16'h00FF, 16'h0000, 0);
    checkOutput("dirFF", resOf(1), 17'h0FF);
    applyStimulus(1, 16'h0000, 16'h00FF, 0);
    checkOutput("dirNeg255", resOf(1), 17'h101);
    applyStimulus(1, 16'h00A5, 16'h005A, 0);
    checkOutput("dir75", resOf(1), 17'h04B);
    applyStimulus(1, 16'h0033, 16'h0033, 0);
    checkOutput("dirZero", resOf(1), 17'h000);
    applyStimulus(1, 16'h0080, 16'h0001, 6);
    checkOutput("dirStall", resOf(1), 17'h07F);

    $display("[TB] reset during BUSY");
    posB       = 16'h005C;
    negB       = 16'h00E1;
    inValid[1] = 1'b1;
    step();
    inValid[1] = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midResetValid", 17'(outValid[1]), 17'd0);
    checkOutput("midResetReady", 17'(inReady[1]), 17'd1);
    checkOutput("midResetResult", resOf(1), 17'd0);
    step();
    rst_n = 1'b1;
    step();
    applyStimulus(1, 16'h0001, 16'h0002, 0);
    checkOutput("afterReset", resOf(1), 17'h1FF);

    $display("[TB] random WIDTH=8");
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(1, 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
    end

    $display("[TB] random WIDTH=4");
    for (int i = 0; i < 150; i++) begin
      applyStimulus(0, 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
    end

    $display("[TB] random WIDTH=16");
    applyStimulus(2, 16'h0000, 16'hFFFF, 1);
    checkOutput("w16Min", resOf(2), 17'h10001);
    for (int i = 0; i < 150; i++) begin
      applyStimulus(2, 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
